// File: rtl/ds_seq_pkg.sv
// Shared encodings for the data-stack sequencer: command opcodes, DSOP strobes,
// error codes and the sequencer FSM state type.
package ds_seq_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_ALU  = 3'd4;
  localparam logic [2:0] OP_PEEK = 3'd5;

  // DSOP bits: [3] pop, [2] push, [1] write sr0, [0] read sr0
  localparam logic [3:0] DSOP_IDLE  = 4'b0000;
  localparam logic [3:0] DSOP_POP   = 4'b1000;
  localparam logic [3:0] DSOP_PUSH  = 4'b0100;
  localparam logic [3:0] DSOP_WRITE = 4'b0010;
  localparam logic [3:0] DSOP_READ  = 4'b0001;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_UNDER   = 2'd1;
  localparam logic [1:0] ERR_OVER    = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_STEP,
    ST_ALU_WAIT,
    ST_ALU_POP,
    ST_ALU_WB,
    ST_FIN
  } ds_state_e;

endpackage

// File: rtl/ds_seq_check.sv
// Combinational error classifier: decides whether a latched command may run
// against the current stack occupancy and overflow flag.
module ds_seq_check
  import ds_seq_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int SIZE_W = 8
) (
  input  logic [2:0]        op,
  input  logic [SIZE_W-1:0] ds_size,
  input  logic              stack_overflow,
  output logic [1:0]        err
);

  always_comb begin
    err = ERR_OK;
    case (op)
      OP_NOP:          err = ERR_OK;
      OP_PUSH, OP_DUP: if (ds_size >= SIZE_W'(DEPTH) || stack_overflow) err = ERR_OVER;
      OP_POP, OP_PEEK: if (ds_size == '0) err = ERR_UNDER;
      OP_ALU:          if (ds_size < SIZE_W'(2)) err = ERR_UNDER;
      default:         err = ERR_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/ds_sequencer.sv
// Expands one stack command into a timed sequence of DSOP/ALUOP steps for the
// data stack and ALU, then reports done/err/resp_* to instruction control.
module ds_sequencer
  import ds_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 128,
  parameter int SIZE_W  = 8,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              async_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [3:0]        DSOP,
  output logic [DATA_W-1:0] ds_data,
  output logic [2:0]        ALUOP,
  input  logic [DATA_W-1:0] sr0_out,
  input  logic [SIZE_W-1:0] ds_size,
  input  logic              stack_overflow,
  input  logic [DATA_W-1:0] ALUOUT,
  input  logic [3:0]        STATUS,
  output logic [DATA_W-1:0] resp_data,
  output logic [3:0]        resp_status,
  output logic              done,
  output logic [1:0]        err,
  output ds_state_e         dbg_state
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  ds_state_e         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [3:0]        stat_q, stat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        dsop_q, dsop_d;
  logic [DATA_W-1:0] ds_data_q, ds_data_d;
  logic [2:0]        aluop_q, aluop_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [3:0]        resp_status_q, resp_status_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [1:0]        chk_err;

  ds_seq_check #(.DEPTH(DEPTH), .SIZE_W(SIZE_W)) u_check (
    .op             (op_q),
    .ds_size        (ds_size),
    .stack_overflow (stack_overflow),
    .err            (chk_err)
  );

  // Command handshake: a command transfers on a rising edge where
  // cmd_valid && cmd_ready. cmd_ready is high only in IDLE; offers made while
  // busy are dropped, so upstream holds cmd_valid until it sees cmd_ready.
  assign cmd_ready = (state_q == ST_IDLE);

  // Registered outputs are computed for the state being entered, so each
  // strobe is visible during exactly the cycle of the step it belongs to.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    data_d        = data_q;
    opnd_d        = opnd_q;
    res_d         = res_q;
    stat_d        = stat_q;
    cnt_d         = cnt_q;
    dsop_d        = DSOP_IDLE;
    ds_data_d     = '0;
    aluop_d       = '0;
    done_d        = 1'b0;
    err_d         = ERR_OK;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        opnd_d = sr0_out;
        if (chk_err != ERR_OK) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          err_d   = chk_err;
        end else if (op_q == OP_NOP) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          state_d = ST_STEP;
          case (op_q)
            OP_PUSH: begin dsop_d = DSOP_PUSH; ds_data_d = data_q;  end
            OP_DUP:  begin dsop_d = DSOP_PUSH; ds_data_d = sr0_out; end
            OP_POP:  dsop_d  = DSOP_POP;
            OP_PEEK: dsop_d  = DSOP_READ;
            OP_ALU:  aluop_d = data_q[2:0];
            default: ;
          endcase
        end
      end
      ST_STEP: begin
        if (op_q == OP_ALU) begin
          state_d = ST_ALU_WAIT;
          aluop_d = aluop_q;
          cnt_d   = CNT_W'(ALU_LAT - 1);
        end else begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          if (op_q == OP_POP || op_q == OP_PEEK) resp_data_d = opnd_q;
        end
      end
      ST_ALU_WAIT: begin
        if (cnt_q == '0) begin
          res_d   = ALUOUT;
          stat_d  = STATUS;
          state_d = ST_ALU_POP;
          dsop_d  = DSOP_POP;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          aluop_d = aluop_q;
        end
      end
      ST_ALU_POP: begin
        state_d   = ST_ALU_WB;
        dsop_d    = DSOP_WRITE;
        ds_data_d = res_q;
      end
      ST_ALU_WB: begin
        state_d       = ST_FIN;
        done_d        = 1'b1;
        resp_data_d   = res_q;
        resp_status_d = stat_q;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (async_reset) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      data_q        <= '0;
      opnd_q        <= '0;
      res_q         <= '0;
      stat_q        <= '0;
      cnt_q         <= '0;
      dsop_q        <= DSOP_IDLE;
      ds_data_q     <= '0;
      aluop_q       <= '0;
      resp_data_q   <= '0;
      resp_status_q <= '0;
      done_q        <= 1'b0;
      err_q         <= ERR_OK;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      data_q        <= data_d;
      opnd_q        <= opnd_d;
      res_q         <= res_d;
      stat_q        <= stat_d;
      cnt_q         <= cnt_d;
      dsop_q        <= dsop_d;
      ds_data_q     <= ds_data_d;
      aluop_q       <= aluop_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign DSOP        = dsop_q;
  assign ds_data     = ds_data_q;
  assign ALUOP       = aluop_q;
  assign resp_data   = resp_data_q;
  assign resp_status = resp_status_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/ds_sequencer.md
Name: ds_sequencer

Overview:
- Control-side driver for the data stack and data processor pair. It is the issuer of DSOP, ds_data and ALUOP, and the consumer of the ALU result and stack status.
- Accepts one stack command at a time over a valid/ready handshake and expands it into a cycle-accurate sequence of stack and ALU operations.
- Reports completion, errors and read-back data to upstream instruction control.

Parameters:
- DATA_W, 16, stack/ALU data width
- DEPTH, 128, stack capacity (entries sr0..sr127)
- SIZE_W, 8, width of ds_size (must hold 0..DEPTH)
- ALU_LAT, 1, cycles from ALUOP driven to ALUOUT valid (≥1)

Ports:
- clk  in  1  clock, rising edge
- async_reset  in  1  reset; synchronous, active-high (port name per codebase convention)
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 ALU, 5 PEEK; others illegal
- cmd_data  in  DATA_W  PUSH literal; for ALU, bits [2:0] = ALUOP
- DSOP  out  4  [3] pop, [2] push, [1] write sr0, [0] read sr0
- ds_data  out  DATA_W  value written/pushed into sr0
- ALUOP  out  3  ALU operation select
- sr0_out  in  DATA_W  stack top
- ds_size  in  SIZE_W  current stack occupancy
- stack_overflow  in  1  stack overflow flag
- ALUOUT  in  DATA_W  ALU result
- STATUS  in  4  ALU flags
- resp_data  out  DATA_W  PEEK/POP value, or ALU result
- resp_status  out  4  STATUS captured on ALU commands
- done  out  1  one-cycle completion pulse
- err  out  2  with done: 0 ok, 1 underflow, 2 overflow, 3 illegal op

Behaviour:
- Reset: state IDLE; DSOP=0, ds_data=0, ALUOP=0, resp_data=0, resp_status=0, done=0, err=0, cmd_ready=1. Reset mid-sequence abandons the command immediately; no further DSOP is issued.
- cmd_ready=1 only in IDLE. A command is accepted on a cycle where cmd_valid&&cmd_ready; cmd_op and cmd_data are latched on acceptance.
- DSOP, ds_data and ALUOP are registered. Each is nonzero for exactly one cycle per stack/ALU step and 0 otherwise.
- FSM states: IDLE, CHECK, STEP, ALU_WAIT, ALU_POP, ALU_WB, FIN.
- CHECK (cycle after accept) evaluates error conditions using ds_size:
  - PUSH or DUP with ds_size==DEPTH or stack_overflow=1 → err=2.
  - POP or PEEK with ds_size==0 → err=1.
  - ALU with ds_size<2 → err=1.
  - Illegal op → err=3.
  - On any error: go to FIN, no DSOP issued, stack unchanged.
- PUSH: STEP drives DSOP=0100, ds_data=literal → FIN. Latency accept→done = 3 cycles.
- POP: STEP drives DSOP=1000, resp_data=sr0_out sampled in CHECK → FIN.
- PEEK: STEP drives DSOP=0001, resp_data=sr0_out → FIN.
- DUP: STEP drives DSOP=0100, ds_data=sr0_out sampled in CHECK → FIN.
- NOP: CHECK → FIN, err=0.
- ALU:
  - STEP drives ALUOP=cmd_data[2:0], which holds through ALU_WAIT.
  - ALU_WAIT lasts ALU_LAT cycles; ALUOUT and STATUS are latched on its last cycle.
  - ALU_POP drives DSOP=1000.
  - ALU_WB drives DSOP=0010, ds_data=latched result.
  - → FIN. Net effect: two operands replaced by one result; ds_size decreases by 1.
- FIN: done=1 for one cycle with err and resp_* valid; cmd_ready returns to 1 on the next cycle. resp_* hold until the next done.
- cmd_valid while busy is ignored and not queued. Upstream must hold cmd_valid until ready.
- ds_size is assumed correct at CHECK because no DSOP is in flight there.

Decomposition:
- Package ds_seq_pkg holds:
  - cmd_op codes
  - DSOP bit indices/constants (DSOP_POP=4'b1000, PUSH=0100, WRITE=0010, READ=0001, IDLE=0000)
  - FSM state enum
  - err codes
- The single module is sufficient. An optional sub-module ds_seq_check (combinational error classifier: cmd_op, ds_size, stack_overflow → err) is natural.

Test Plan:
- Reset, then PUSH 0x1234 at ds_size=0 → DSOP=0100 with ds_data=0x1234 for one cycle; done 3 cycles after accept, err=0.
- Stack [sr0=5, sr1=3], ALU op=ADD(0) → ALUOP=0 in STEP; DSOP=1000 then DSOP=0010 with ds_data=8 on consecutive cycles; resp_data=8; ds_size 2→1.
- POP at ds_size=0 → no nonzero DSOP; done with err=1. PUSH at ds_size=128 → err=2, no DSOP.
- DUP with sr0=0xBEEF, ds_size=4 → DSOP=0100, ds_data=0xBEEF; PEEK afterwards → resp_data=0xBEEF, DSOP=0001.
- cmd_op=7 → err=3; and cmd_valid held during an ALU sequence → cmd_ready=0 and the command is not accepted until the cycle after done.
- Assert async_reset during ALU_WAIT → next cycle IDLE, all outputs 0, no pop/write issued, cmd_ready=1.
